// File: rtl/pfgen_stride.sv
// Stride prefetch generator. Each table entry tracks one hashed load PC. A
// D-cache miss either trains its entry or allocates a new one. Once the same
// non-zero line stride has been seen often enough, a prefetch op is issued
// through a single registered output slot that holds steady under backpressure.
module pfgen_stride #(
  parameter int NENT     = 4,
  parameter int PC_W     = 12,
  parameter int ADDR_W   = 39,
  parameter int STRIDE_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dctopfg_miss_valid,
  output logic                dctopfg_miss_retry,
  input  logic [PC_W-1:0]     dctopfg_miss_pc,
  input  logic [ADDR_W-1:0]   dctopfg_miss_laddr,
  output logic                pfgtopfe_op_valid,
  input  logic                pfgtopfe_op_retry,
  output logic [ADDR_W-1:0]   pfgtopfe_op_laddr,
  output logic [STRIDE_W-1:0] pfgtopfe_op_stride,
  output logic [1:0]          pfgtopfe_op_degree,
  output logic [15:0]         pfg_nissued
);

  localparam int IDX_W = (NENT > 1) ? $clog2(NENT) : 1;

  // Sign-extends a line stride to the full line-address width.
  function automatic logic [ADDR_W-1:0] sext_stride(input logic signed [STRIDE_W-1:0] s);
    return {{(ADDR_W-STRIDE_W){s[STRIDE_W-1]}}, s};
  endfunction

  // True when an address difference is representable as a signed stride.
  function automatic logic stride_fits(input logic [ADDR_W-1:0] d);
    return ({{(ADDR_W-STRIDE_W){d[STRIDE_W-1]}}, d[STRIDE_W-1:0]} == d);
  endfunction

  // Confidence counter increment that saturates at 3.
  function automatic logic [1:0] conf_sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  // Stride table.
  logic                       ent_vld    [NENT];
  logic [PC_W-1:0]            ent_tag    [NENT];
  logic [ADDR_W-1:0]          ent_last   [NENT];
  logic signed [STRIDE_W-1:0] ent_stride [NENT];
  logic [1:0]                 ent_conf   [NENT];
  logic [IDX_W-1:0]           rr_ptr;

  // Stage p0: lookup and update computation for the offered miss.
  logic                       accept_p0;
  logic                       hit_p0;
  logic [IDX_W-1:0]           hit_idx_p0;
  logic                       free_p0;
  logic [IDX_W-1:0]           free_idx_p0;
  logic [IDX_W-1:0]           alloc_idx_p0;
  logic [ADDR_W-1:0]          delta_p0;
  logic                       delta_fits_p0;
  logic signed [STRIDE_W-1:0] delta_s_p0;
  logic signed [STRIDE_W-1:0] cur_stride_p0;
  logic [1:0]                 cur_conf_p0;
  logic                       same_p0;
  logic [1:0]                 upd_conf_p0;
  logic signed [STRIDE_W-1:0] upd_stride_p0;
  logic                       gen_p0;
  logic [ADDR_W-1:0]          gen_laddr_p0;
  logic [1:0]                 gen_degree_p0;

  // Stage p1: registered output slot.
  logic                       vld_p1;
  logic [ADDR_W-1:0]          op_laddr_p1;
  logic signed [STRIDE_W-1:0] op_stride_p1;
  logic [1:0]                 op_degree_p1;
  logic [15:0]                nissued_p1;
  logic                       xfer_p1;

  assign xfer_p1            = vld_p1 & ~pfgtopfe_op_retry;
  assign dctopfg_miss_retry = vld_p1 & pfgtopfe_op_retry;
  assign accept_p0          = dctopfg_miss_valid & ~dctopfg_miss_retry;

  assign pfgtopfe_op_valid  = vld_p1;
  assign pfgtopfe_op_laddr  = op_laddr_p1;
  assign pfgtopfe_op_stride = op_stride_p1;
  assign pfgtopfe_op_degree = op_degree_p1;
  assign pfg_nissued        = nissued_p1;

  // Tag match across valid entries and lowest-index free entry search.
  always_comb begin
    hit_p0      = 1'b0;
    hit_idx_p0  = '0;
    free_p0     = 1'b0;
    free_idx_p0 = '0;
    for (int i = 0; i < NENT; i++) begin
      if (ent_vld[i] && (ent_tag[i] == dctopfg_miss_pc)) begin
        hit_p0     = 1'b1;
        hit_idx_p0 = IDX_W'(i);
      end
    end
    for (int i = NENT - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        free_p0     = 1'b1;
        free_idx_p0 = IDX_W'(i);
      end
    end
  end

  assign alloc_idx_p0 = free_p0 ? free_idx_p0 : rr_ptr;

  // Training update of the hit entry and the prefetch op it may produce.
  always_comb begin
    cur_stride_p0 = ent_stride[hit_idx_p0];
    cur_conf_p0   = ent_conf[hit_idx_p0];
    delta_p0      = dctopfg_miss_laddr - ent_last[hit_idx_p0];
    delta_fits_p0 = stride_fits(delta_p0);
    delta_s_p0    = delta_p0[STRIDE_W-1:0];
    same_p0       = delta_fits_p0 && (delta_s_p0 != '0) && (delta_s_p0 == cur_stride_p0);
    upd_conf_p0   = same_p0 ? conf_sat_inc(cur_conf_p0) : 2'd0;
    if (same_p0) begin
      upd_stride_p0 = cur_stride_p0;
    end else if (delta_fits_p0) begin
      upd_stride_p0 = delta_s_p0;
    end else begin
      upd_stride_p0 = '0;
    end
    gen_p0        = accept_p0 && hit_p0 && (upd_conf_p0 >= 2'd2) && (upd_stride_p0 != '0);
    gen_laddr_p0  = dctopfg_miss_laddr + sext_stride(upd_stride_p0);
    gen_degree_p0 = (upd_conf_p0 == 2'd3) ? 2'd2 : 2'd1;
  end

  // Table write: train on a hit, otherwise allocate (round-robin when full).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NENT; i++) begin
        ent_vld[i]    <= 1'b0;
        ent_conf[i]   <= 2'd0;
        ent_stride[i] <= '0;
      end
      rr_ptr <= '0;
    end else if (accept_p0) begin
      if (hit_p0) begin
        ent_last[hit_idx_p0]   <= dctopfg_miss_laddr;
        ent_stride[hit_idx_p0] <= upd_stride_p0;
        ent_conf[hit_idx_p0]   <= upd_conf_p0;
      end else begin
        ent_vld[alloc_idx_p0]    <= 1'b1;
        ent_tag[alloc_idx_p0]    <= dctopfg_miss_pc;
        ent_last[alloc_idx_p0]   <= dctopfg_miss_laddr;
        ent_stride[alloc_idx_p0] <= '0;
        ent_conf[alloc_idx_p0]   <= 2'd0;
        if (!free_p0) begin
          rr_ptr <= (rr_ptr == IDX_W'(NENT - 1)) ? '0 : rr_ptr + IDX_W'(1);
        end
      end
    end
  end

  // Output slot: a new op may only arrive when the slot is empty or draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      op_laddr_p1  <= '0;
      op_stride_p1 <= '0;
      op_degree_p1 <= 2'd0;
    end else if (gen_p0) begin
      vld_p1       <= 1'b1;
      op_laddr_p1  <= gen_laddr_p0;
      op_stride_p1 <= upd_stride_p0;
      op_degree_p1 <= gen_degree_p0;
    end else if (xfer_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  // Wrapping count of ops handed to the prefetch engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      nissued_p1 <= 16'd0;
    end else if (xfer_p1) begin
      nissued_p1 <= nissued_p1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_pfgen_stride.sv
// Directed bench for pfgen_stride: expected prefetch ops are queued when the
// triggering miss is driven and compared when the engine side takes them.
module tb_pfgen_stride;

  logic        clk = 1'b0;
  logic        reset;
  logic        dctopfg_miss_valid;
  logic        dctopfg_miss_retry;
  logic [11:0] dctopfg_miss_pc;
  logic [38:0] dctopfg_miss_laddr;
  logic        pfgtopfe_op_valid;
  logic        pfgtopfe_op_retry;
  logic [38:0] pfgtopfe_op_laddr;
  logic [11:0] pfgtopfe_op_stride;
  logic [1:0]  pfgtopfe_op_degree;
  logic [15:0] pfg_nissued;

  int total = 0;
  int bad   = 0;
  logic [52:0] exp_q[$];
  logic [52:0] mon_op;

  always #5 clk = ~clk;

  pfgen_stride dut (
    .clk                (clk),
    .reset              (reset),
    .dctopfg_miss_valid (dctopfg_miss_valid),
    .dctopfg_miss_retry (dctopfg_miss_retry),
    .dctopfg_miss_pc    (dctopfg_miss_pc),
    .dctopfg_miss_laddr (dctopfg_miss_laddr),
    .pfgtopfe_op_valid  (pfgtopfe_op_valid),
    .pfgtopfe_op_retry  (pfgtopfe_op_retry),
    .pfgtopfe_op_laddr  (pfgtopfe_op_laddr),
    .pfgtopfe_op_stride (pfgtopfe_op_stride),
    .pfgtopfe_op_degree (pfgtopfe_op_degree),
    .pfg_nissued        (pfg_nissued)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle miss; when gen is set the op it must produce is queued.
  task automatic miss(input logic [11:0] pc, input logic [38:0] la, input bit gen,
                      input logic [38:0] ela, input logic [11:0] es, input logic [1:0] ed);
    dctopfg_miss_valid = 1'b1;
    dctopfg_miss_pc    = pc;
    dctopfg_miss_laddr = la;
    if (gen) exp_q.push_back({ela, es, ed});
    tick();
    dctopfg_miss_valid = 1'b0;
  endtask

  // Let outstanding ops drain, then confirm all expected ops arrived.
  task automatic quiet(input string tag, input int n);
    repeat (2) tick();
    @(negedge clk);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_nissued"}, 64'(pfg_nissued), 64'(n));
    exp_q.delete();
    tick();
  endtask

  // Engine-side scoreboard: every transfer must match the oldest expected op.
  always @(negedge clk) begin
    if (!reset && pfgtopfe_op_valid && !pfgtopfe_op_retry) begin
      check("op_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_op = exp_q.pop_front();
        check("op_laddr",  64'(pfgtopfe_op_laddr),  64'(mon_op[52:14]));
        check("op_stride", 64'(pfgtopfe_op_stride), 64'(mon_op[13:2]));
        check("op_degree", 64'(pfgtopfe_op_degree), 64'(mon_op[1:0]));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    dctopfg_miss_valid = 1'b0;
    dctopfg_miss_pc    = '0;
    dctopfg_miss_laddr = '0;
    pfgtopfe_op_retry  = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_op_valid",   64'(pfgtopfe_op_valid),  64'd0);
    check("rst_nissued",    64'(pfg_nissued),        64'd0);
    check("rst_miss_retry", 64'(dctopfg_miss_retry), 64'd0);
    check("rst_laddr",      64'(pfgtopfe_op_laddr),  64'd0);
    check("rst_stride",     64'(pfgtopfe_op_stride), 64'd0);
    check("rst_degree",     64'(pfgtopfe_op_degree), 64'd0);
    tick();
    reset = 1'b0;

    // Train +4 stride: confidence reaches 2 on the fourth miss, 3 on the fifth.
    miss(12'h010, 39'h100, 0, '0, '0, '0);
    miss(12'h010, 39'h104, 0, '0, '0, '0);
    miss(12'h010, 39'h108, 0, '0, '0, '0);
    miss(12'h010, 39'h10C, 1, 39'h110, 12'd4, 2'd1);
    miss(12'h010, 39'h110, 1, 39'h114, 12'd4, 2'd2);
    quiet("train", 2);

    // Negative stride.
    miss(12'h020, 39'h200, 0, '0, '0, '0);
    miss(12'h020, 39'h1FE, 0, '0, '0, '0);
    miss(12'h020, 39'h1FC, 0, '0, '0, '0);
    miss(12'h020, 39'h1FA, 1, 39'h1F8, 12'hFFE, 2'd1);
    quiet("neg", 3);

    // Backpressure: a stray miss offered during the stall must be refused.
    miss(12'h030, 39'h300, 0, '0, '0, '0);
    miss(12'h030, 39'h308, 0, '0, '0, '0);
    miss(12'h030, 39'h310, 0, '0, '0, '0);
    pfgtopfe_op_retry = 1'b1;
    miss(12'h030, 39'h318, 1, 39'h320, 12'd8, 2'd1);
    dctopfg_miss_valid = 1'b1;
    dctopfg_miss_pc    = 12'h030;
    dctopfg_miss_laddr = 39'h5000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid",      64'(pfgtopfe_op_valid),  64'd1);
      check("stall_laddr",      64'(pfgtopfe_op_laddr),  64'h320);
      check("stall_stride",     64'(pfgtopfe_op_stride), 64'd8);
      check("stall_degree",     64'(pfgtopfe_op_degree), 64'd1);
      check("stall_miss_retry", 64'(dctopfg_miss_retry), 64'd1);
      tick();
    end
    dctopfg_miss_valid = 1'b0;
    pfgtopfe_op_retry  = 1'b0;
    @(negedge clk);
    check("release_miss_retry", 64'(dctopfg_miss_retry), 64'd0);
    tick();
    miss(12'h030, 39'h320, 1, 39'h328, 12'd8, 2'd2);
    quiet("bp", 5);

    // Reset while an op is pending drops it and forgets all training.
    miss(12'h011, 39'h0F0, 0, '0, '0, '0);
    miss(12'h011, 39'h0F4, 0, '0, '0, '0);
    miss(12'h011, 39'h0F8, 0, '0, '0, '0);
    pfgtopfe_op_retry = 1'b1;
    miss(12'h011, 39'h0FC, 0, '0, '0, '0);
    @(negedge clk);
    check("pend_valid", 64'(pfgtopfe_op_valid), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid",   64'(pfgtopfe_op_valid),  64'd0);
    check("midrst_nissued", 64'(pfg_nissued),        64'd0);
    check("midrst_laddr",   64'(pfgtopfe_op_laddr),  64'd0);
    check("midrst_stride",  64'(pfgtopfe_op_stride), 64'd0);
    check("midrst_degree",  64'(pfgtopfe_op_degree), 64'd0);
    pfgtopfe_op_retry = 1'b0;
    tick();
    miss(12'h011, 39'h100, 0, '0, '0, '0);
    miss(12'h011, 39'h104, 0, '0, '0, '0);
    miss(12'h011, 39'h108, 0, '0, '0, '0);
    miss(12'h011, 39'h10C, 1, 39'h110, 12'd4, 2'd1);
    quiet("retrain", 1);

    // Replacement: fifth PC evicts entry 0, re-missed PC evicts entry 1.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    miss(12'h041, 39'h1000, 0, '0, '0, '0);
    miss(12'h041, 39'h1004, 0, '0, '0, '0);
    miss(12'h041, 39'h1008, 0, '0, '0, '0);
    miss(12'h042, 39'h2000, 0, '0, '0, '0);
    miss(12'h043, 39'h3000, 0, '0, '0, '0);
    miss(12'h044, 39'h4000, 0, '0, '0, '0);
    miss(12'h045, 39'h5000, 0, '0, '0, '0);
    miss(12'h041, 39'h100C, 0, '0, '0, '0);
    miss(12'h041, 39'h1010, 0, '0, '0, '0);
    miss(12'h045, 39'h5004, 0, '0, '0, '0);
    miss(12'h045, 39'h5008, 0, '0, '0, '0);
    miss(12'h045, 39'h500C, 1, 39'h5010, 12'd4, 2'd1);
    quiet("repl", 1);

    // Stride +0x800 does not fit; -0x800 is the most negative stride that does.
    miss(12'h060, 39'h6000, 0, '0, '0, '0);
    miss(12'h060, 39'h6800, 0, '0, '0, '0);
    miss(12'h060, 39'h7000, 0, '0, '0, '0);
    miss(12'h060, 39'h7800, 0, '0, '0, '0);
    miss(12'h061, 39'h9000, 0, '0, '0, '0);
    miss(12'h061, 39'h8800, 0, '0, '0, '0);
    miss(12'h061, 39'h8000, 0, '0, '0, '0);
    miss(12'h061, 39'h7800, 1, 39'h7000, 12'h800, 2'd1);
    quiet("ovf", 2);

    // Address wrap at the top of the line-address space.
    miss(12'h062, 39'h7F_FFFF_FFFC, 0, '0, '0, '0);
    miss(12'h062, 39'h7F_FFFF_FFFD, 0, '0, '0, '0);
    miss(12'h062, 39'h7F_FFFF_FFFE, 0, '0, '0, '0);
    miss(12'h062, 39'h7F_FFFF_FFFF, 1, 39'h0, 12'd1, 2'd1);
    miss(12'h062, 39'h0, 1, 39'h1, 12'd1, 2'd2);
    quiet("wrap", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
